// File: rtl/ltc2668_dac_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ltc2668_pkg
//  Description : Shared constants and state type for the LTC2668 DAC writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ltc2668_pkg;

    localparam int         FRAME_BITS  = 24;
    localparam logic [3:0] CMD_WR_UPD  = 4'h3;
    localparam logic [3:0] CMD_WR      = 4'h0;
    localparam logic [3:0] CMD_UPD_ALL = 4'h9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/ltc2668_dac_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ltc2668_dac_writer_if
//  Description : Register write/read bus from the SPI slave command decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ltc2668_dac_writer_if;

    logic        i_write;
    logic [3:0]  i_waddr;
    logic [15:0] i_wrData;
    logic [3:0]  i_raddr;
    logic [15:0] o_reData;

    modport master (
        output i_write,
        output i_waddr,
        output i_wrData,
        output i_raddr,
        input  o_reData
    );

    modport slave (
        input  i_write,
        input  i_waddr,
        input  i_wrData,
        input  i_raddr,
        output o_reData
    );

endinterface
`default_nettype wire

// File: rtl/ltc2668_dac_writer_spi_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_tx
//  Description : 24-bit MSB-first SPI master frame sender with CS framing.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_tx
    import ltc2668_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_start,
    input  wire logic [FRAME_BITS-1:0] i_frame,
    output logic                       o_sclk,
    output logic                       o_cs_n,
    output logic                       o_mosi,
    output logic                       o_active
);

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] c_BIT_LAST = 5'(FRAME_BITS - 1);

    tx_state_t             r_state;
    logic [7:0]            r_div;
    logic [4:0]            r_bit;
    // Bit 23 goes straight to MOSI at load, so only the remaining bits are kept
    logic [FRAME_BITS-2:0] r_shreg;
    logic                  r_sclk;
    logic                  r_cs_n;
    logic                  r_mosi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_sclk  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_shreg <= i_frame[FRAME_BITS-2:0];
                        r_mosi  <= i_frame[FRAME_BITS-1];
                        r_cs_n  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_div   <= '0;
                    r_bit   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit == c_BIT_LAST) begin
                                r_state <= HOLD;
                            end else begin
                                r_bit   <= r_bit + 5'd1;
                                r_mosi  <= r_shreg[FRAME_BITS-2];
                                r_shreg <= {r_shreg[FRAME_BITS-3:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                HOLD: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div   <= '0;
                        r_cs_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= GAP;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                GAP: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_sclk   = r_sclk;
    assign o_cs_n   = r_cs_n;
    assign o_mosi   = r_mosi;
    assign o_active = (r_state != IDLE);

endmodule
`default_nettype wire

// File: rtl/ltc2668_dac_writer.sv
`default_nettype none
// ============================================================================
//  Module      : ltc2668_dac_writer
//  Description : 16-channel code bank with round-robin write-and-update to LTC2668.
//  Revision    : 1.0 - initial release
// ============================================================================
module ltc2668_dac_writer
    import ltc2668_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter logic [3:0] CMD_WR_UPD = ltc2668_pkg::CMD_WR_UPD
) (
    input  wire logic            i_FPGA_clk,
    input  wire logic            i_FPGA_rst,
    ltc2668_dac_writer_if.slave  bus,
    output logic                 o_dac_sclk,
    output logic                 o_dac_cs_n,
    output logic                 o_dac_mosi,
    output logic                 o_busy
);

    logic [15:0]           r_regs [16];
    logic [15:0]           r_pending;
    logic [3:0]            r_rr_ptr;
    logic [15:0]           r_reData;

    logic                  w_found;
    logic [3:0]            w_pick;
    logic                  w_tx_active;
    logic                  w_start;
    logic [FRAME_BITS-1:0] w_frame;

    // Descending scan so the smallest offset from r_rr_ptr is the last to assign
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int i = 15; i >= 0; i--) begin
            if (r_pending[r_rr_ptr + 4'(i)]) begin
                w_found = 1'b1;
                w_pick  = r_rr_ptr + 4'(i);
            end
        end
    end

    assign w_start = !w_tx_active && w_found;
    assign w_frame = {CMD_WR_UPD, w_pick, r_regs[w_pick]};

    always_ff @(posedge i_FPGA_clk) begin
        if (i_FPGA_rst) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_reData  <= '0;
        end else begin
            r_reData <= r_regs[bus.i_raddr];
            if (bus.i_write) begin
                r_regs[bus.i_waddr] <= bus.i_wrData;
            end
            if (w_start) begin
                r_pending[w_pick] <= 1'b0;
                r_rr_ptr          <= w_pick + 4'd1;
            end
            // Placed after the clear so a fresh write to the launched channel stays pending
            if (bus.i_write) begin
                r_pending[bus.i_waddr] <= 1'b1;
            end
        end
    end

    spi_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk      (i_FPGA_clk),
        .rst      (i_FPGA_rst),
        .i_start  (w_start),
        .i_frame  (w_frame),
        .o_sclk   (o_dac_sclk),
        .o_cs_n   (o_dac_cs_n),
        .o_mosi   (o_dac_mosi),
        .o_active (w_tx_active)
    );

    assign bus.o_reData = r_reData;
    assign o_busy       = (|r_pending) | w_tx_active;

endmodule
`default_nettype wire
